// File: rtl/usb_line_tx_if.sv
// Word handshake between a packet source and the USB line transmitter.
interface usb_line_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_last;
  logic             data_ready;

  modport master (output data_in, output data_valid, output data_last, input data_ready);
  modport slave  (input data_in, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/usb_line_tx.sv
// Serialises words onto a D+/D- pair: SYNC, NRZI coding with bit stuffing,
// then an SE0/J end-of-packet. One line bit per clock.
module usb_line_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STUFF_RUN = 6,
  parameter int unsigned EOP_SE0   = 2
) (
  input  logic         clk,
  input  logic         rst_L,
  usb_line_tx_if.slave bus,
  output logic         d_p,
  output logic         d_m,
  output logic         busy,
  output logic         err
);
  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);
  localparam int unsigned CNT_W  = 3;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [ONES_W-1:0] RUN_MAX  = ONES_W'(STUFF_RUN);
  localparam logic [CNT_W-1:0]  EOP_LAST = CNT_W'(EOP_SE0 - 1);
  localparam logic [CNT_W-1:0]  SYNC_END = CNT_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_EOPJ
  } state_e;

  state_e             state_q, state_d;
  logic               level_q, level_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               last_q, last_d;
  logic               stuff_q, stuff_d;
  logic               fin_q, fin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               d_p_q, d_p_d;
  logic               d_m_q, d_m_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic send_raw, send_stuff, raw, owe, xfer, line_on;

  // Registers hold what the line carries in the current cycle.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      level_q <= 1'b1;
      ones_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      stuff_q <= 1'b0;
      fin_q   <= 1'b0;
      cnt_q   <= '0;
      d_p_q   <= 1'b1;
      d_m_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      stuff_q <= stuff_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
      d_p_q   <= d_p_d;
      d_m_q   <= d_m_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Decide the content of the next line cycle, then derive its outputs.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    stuff_d    = 1'b0;
    fin_d      = fin_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    send_raw   = 1'b0;
    send_stuff = 1'b0;
    raw        = 1'b0;
    xfer       = bus.data_valid & ready_q;
    owe        = (ones_q == RUN_MAX);

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shreg_d  = bus.data_in;
          last_d   = bus.data_last;
          cnt_d    = '0;
          state_d  = ST_SYNC;
          send_raw = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == SYNC_END) begin
          state_d = ST_DATA;
          bit_d   = '0;
          if (owe) begin
            send_stuff = 1'b1;
          end else begin
            send_raw = 1'b1;
            raw      = shreg_q[0];
          end
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          send_raw = 1'b1;
          raw      = (cnt_q == CNT_W'(6));
        end
      end
      ST_DATA: begin
        if (stuff_q) begin
          // A stuff cycle never owes another, since it clears the run.
          if (fin_q) begin
            state_d = ST_EOP;
            cnt_d   = '0;
          end else begin
            send_raw = 1'b1;
            raw      = shreg_q[bit_q];
          end
        end else if (bit_q != LAST_BIT) begin
          bit_d = bit_q + BIT_W'(1);
          if (owe) begin
            send_stuff = 1'b1;
          end else begin
            send_raw = 1'b1;
            raw      = shreg_q[bit_d];
          end
        end else if (!last_q && xfer) begin
          shreg_d = bus.data_in;
          last_d  = bus.data_last;
          bit_d   = '0;
          if (owe) begin
            send_stuff = 1'b1;
          end else begin
            send_raw = 1'b1;
            raw      = bus.data_in[0];
          end
        end else begin
          err_d = ~last_q;
          if (owe) begin
            send_stuff = 1'b1;
            fin_d      = 1'b1;
          end else begin
            state_d = ST_EOP;
            cnt_d   = '0;
          end
        end
      end
      ST_EOP: begin
        if (cnt_q == EOP_LAST) begin
          state_d = ST_EOPJ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EOPJ: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // NRZI: a 0 (stuffed or raw) toggles the level, a 1 holds it.
    if (send_stuff) begin
      level_d = ~level_q;
      ones_d  = '0;
      stuff_d = 1'b1;
    end else if (send_raw) begin
      level_d = raw ? level_q : ~level_q;
      ones_d  = raw ? ones_q + ONES_W'(1) : '0;
    end

    if (state_d == ST_IDLE || state_d == ST_EOP || state_d == ST_EOPJ) begin
      level_d = 1'b1;
      ones_d  = '0;
      fin_d   = 1'b0;
    end

    line_on = (state_d == ST_SYNC) || (state_d == ST_DATA);
    d_p_d   = line_on ? level_d : (state_d != ST_EOP);
    d_m_d   = line_on ? ~level_d : 1'b0;
    ready_d = (state_d == ST_IDLE) ||
              ((state_d == ST_DATA) && !stuff_d && (bit_d == LAST_BIT) && !last_d);
    busy_d  = (state_d != ST_IDLE);
  end

  assign bus.data_ready = ready_q;
  assign d_p            = d_p_q;
  assign d_m            = d_m_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: tb/tb_usb_line_tx.sv
// Bench for usb_line_tx: directed and random packets checked cycle by cycle
// against a bit-stream model of the line (sync + data, stuffing, NRZI, EOP).
module tb_usb_line_tx;
  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic dp_a, dm_a, busy_a, err_a;
  logic dp_b, dm_b, busy_b, err_b;

  usb_line_tx_if #(.WIDTH(8)) ifa ();
  usb_line_tx_if #(.WIDTH(8)) ifb ();

  usb_line_tx #(.WIDTH(8), .STUFF_RUN(6), .EOP_SE0(2)) dut_a (
    .clk(clk), .rst_L(rst_L), .bus(ifa),
    .d_p(dp_a), .d_m(dm_a), .busy(busy_a), .err(err_a)
  );
  usb_line_tx #(.WIDTH(8), .STUFF_RUN(3), .EOP_SE0(3)) dut_b (
    .clk(clk), .rst_L(rst_L), .bus(ifb),
    .d_p(dp_b), .d_m(dm_b), .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] words_q[$];
  bit         underrun;
  logic [4:0] exp_q[$];   // {d_p, d_m, busy, data_ready, err}
  logic       m_lvl;
  int         m_ones;
  logic       err_pend;
  int         busy_cnt, err_cnt, rdy_busy_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic void put(input logic dp, input logic dm, input logic rdy);
    exp_q.push_back({dp, dm, 1'b1, rdy, err_pend});
    err_pend = 1'b0;
  endfunction

  function automatic void send_bit(input logic b, input logic rdy, input logic urun, input int sr);
    if (!b) m_lvl = !m_lvl;
    put(m_lvl, !m_lvl, rdy);
    if (urun) err_pend = 1'b1;
    m_ones = b ? m_ones + 1 : 0;
    if (m_ones == sr) begin
      m_lvl = !m_lvl;
      put(m_lvl, !m_lvl, 1'b0);
      m_ones = 0;
    end
  endfunction

  function automatic void build_exp(input int sr, input int es);
    int n;
    logic [7:0] wd;
    bit is_last;
    n = words_q.size();
    exp_q.delete();
    err_pend = 1'b0;
    m_lvl = 1'b1;
    m_ones = 0;
    exp_q.push_back(5'b10010);
    for (int i = 0; i < 8; i++) send_bit(i == 7, 1'b0, 1'b0, sr);
    for (int w = 0; w < n; w++) begin
      wd = words_q[w];
      is_last = !underrun && (w == n - 1);
      for (int b = 0; b < 8; b++)
        send_bit(wd[b], (b == 7) && !is_last, (b == 7) && underrun && (w == n - 1), sr);
    end
    for (int e = 0; e < es; e++) put(1'b0, 1'b0, 1'b0);
    exp_q.push_back(5'b10100);
    exp_q.push_back(5'b10010);
  endfunction

  function automatic logic [4:0] observe(input int sel);
    if (sel == 0) return {dp_a, dm_a, busy_a, ifa.data_ready, err_a};
    return {dp_b, dm_b, busy_b, ifb.data_ready, err_b};
  endfunction

  task automatic drive(input int sel, input int idx);
    logic [7:0] d;
    logic v, l;
    if (idx < words_q.size()) begin
      v = 1'b1;
      d = words_q[idx];
      l = !underrun && (idx == words_q.size() - 1);
    end else begin
      v = 1'b0;
      d = 8'($urandom);
      l = 1'($urandom);
    end
    if (sel == 0) begin
      ifa.data_valid = v; ifa.data_in = d; ifa.data_last = l;
    end else begin
      ifb.data_valid = v; ifb.data_in = d; ifb.data_last = l;
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_pkt(input int sel, input int stop_at);
    int idx;
    bit pend;
    logic [4:0] obs;
    build_exp(sel == 0 ? 6 : 3, sel == 0 ? 2 : 3);
    idx = 0;
    pend = 1'b0;
    busy_cnt = 0;
    err_cnt = 0;
    rdy_busy_cnt = 0;
    drive(sel, 0);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (pend) begin
          idx++;
          drive(sel, idx);
        end
      end
      obs = observe(sel);
      chk($sformatf("line dut%0d cyc%0d", sel, c), 32'(obs), 32'(exp_q[c]));
      busy_cnt += int'(obs[2]);
      err_cnt += int'(obs[0]);
      rdy_busy_cnt += int'(obs[2] & obs[1]);
      pend = obs[1] && (idx < words_q.size());
      if (c == stop_at) return;
    end
  endtask

  task automatic set_pkt(input logic [7:0] w0, input int n, input logic [7:0] w1, input bit ur);
    words_q.delete();
    words_q.push_back(w0);
    if (n > 1) words_q.push_back(w1);
    underrun = ur;
  endtask

  initial begin
    ifa.data_valid = 1'b0; ifa.data_in = '0; ifa.data_last = 1'b0;
    ifb.data_valid = 1'b0; ifb.data_in = '0; ifb.data_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", 32'(observe(0)), 32'h12);
    chk("reset_b", 32'(observe(1)), 32'h12);
    rst_L = 1'b1;
    @(negedge clk);

    set_pkt(8'h00, 1, 8'h00, 1'b0);
    run_pkt(0, -1);
    chk("busy_00", busy_cnt, 19);
    chk("err_00", err_cnt, 0);

    set_pkt(8'hFF, 1, 8'h00, 1'b0);
    run_pkt(0, -1);
    chk("busy_ff", busy_cnt, 20);

    set_pkt(8'h0F, 2, 8'hA5, 1'b0);
    run_pkt(0, -1);
    chk("busy_0f_a5", busy_cnt, 27);
    chk("rdy_pulses_0f_a5", rdy_busy_cnt, 1);

    set_pkt(8'h3C, 1, 8'h00, 1'b1);
    run_pkt(0, -1);
    chk("err_underrun", err_cnt, 1);
    chk("busy_underrun", busy_cnt, 19);

    set_pkt(8'h00, 1, 8'h00, 1'b0);
    run_pkt(0, 12);
    ifa.data_valid = 1'b0;
    rst_L = 1'b0;
    #1;
    chk("abort_reset_a", 32'(observe(0)), 32'h12);
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    set_pkt(8'($urandom), 1, 8'h00, 1'b0);
    run_pkt(0, -1);

    set_pkt(8'h07, 1, 8'h00, 1'b0);
    run_pkt(1, -1);
    chk("busy_b_07", busy_cnt, 21);

    set_pkt(8'hFF, 1, 8'h00, 1'b0);
    run_pkt(1, -1);
    chk("busy_b_ff", busy_cnt, 23);

    set_pkt(8'hFF, 2, 8'h01, 1'b0);
    run_pkt(1, -1);

    for (int p = 0; p < 16; p++) begin
      int sel;
      int n;
      sel = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back(8'($urandom));
      underrun = ($urandom_range(0, 3) == 0);
      run_pkt(sel, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
